// File: rtl/key_search_ctrl.sv
// key_search_ctrl: sweeps the key range [min_key, max_key] across N_CORES cracking cores in lockstep batches.
// Optional macro KEY_SEARCH_CYCLE_COUNT_EN builds the search_cycles counter; without it search_cycles is tied to 0.
module key_search_ctrl #(
    parameter int KEY_W   = 24,
    parameter int N_CORES = 4,
    parameter int IDX_W   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       halt,
    input  logic [KEY_W-1:0]           min_key,
    input  logic [KEY_W-1:0]           max_key,
    output logic [N_CORES-1:0]         core_start,
    output logic [N_CORES*KEY_W-1:0]   core_key,
    input  logic [N_CORES-1:0]         core_finish,
    input  logic [N_CORES-1:0]         core_valid,
    output logic                       busy,
    output logic                       found,
    output logic                       not_found,
    output logic [KEY_W-1:0]           found_key,
    output logic [IDX_W-1:0]           found_core,
    output logic [KEY_W-1:0]           display_key,
    output logic [31:0]                search_cycles
);

    // Core handshake: core_start[i] is a one-cycle pulse and core_key[i] is held until the batch is
    // evaluated; core_finish[i] is a one-cycle pulse and core_valid[i] is only meaningful in that cycle.
    localparam int EXT_W = KEY_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_EVAL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [KEY_W-1:0]           base_q, base_d;
    logic [KEY_W-1:0]           max_q, max_d;
    logic [N_CORES-1:0]         done_mask_q, done_mask_d;
    logic [N_CORES-1:0]         valid_mask_q, valid_mask_d;
    logic                       found_q, found_d;
    logic                       not_found_q, not_found_d;
    logic [KEY_W-1:0]           found_key_q, found_key_d;
    logic [IDX_W-1:0]           found_core_q, found_core_d;
    logic [N_CORES*KEY_W-1:0]   core_key_q, core_key_d;
    logic [KEY_W-1:0]           display_q, display_d;

    logic [N_CORES-1:0]         active_c;
    logic                       win_any;
    logic [IDX_W-1:0]           win_idx;
    logic                       start_accept;
    logic                       load_launch;
    logic [KEY_W-1:0]           launch_base;

    assign start_accept = start && !halt && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Extra top bit keeps base+i from wrapping past the all-ones key.
    always_comb begin
        active_c = '0;
        for (int i = 0; i < N_CORES; i++) begin
            active_c[i] = (({1'b0, base_q} + EXT_W'(i)) <= {1'b0, max_q});
        end
    end

    // Descending scan so the lowest valid index wins.
    always_comb begin
        win_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (valid_mask_q[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end
    assign win_any = |valid_mask_q;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        max_d        = max_q;
        done_mask_d  = done_mask_q;
        valid_mask_d = valid_mask_q;
        found_d      = found_q;
        not_found_d  = not_found_q;
        found_key_d  = found_key_q;
        found_core_d = found_core_q;
        core_key_d   = core_key_q;
        display_d    = display_q;
        core_start   = '0;
        load_launch  = 1'b0;
        launch_base  = base_q;

        if (halt) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_accept) begin
                        max_d        = max_key;
                        base_d       = min_key;
                        found_d      = 1'b0;
                        not_found_d  = 1'b0;
                        found_key_d  = '0;
                        found_core_d = '0;
                        done_mask_d  = '0;
                        valid_mask_d = '0;
                        load_launch  = 1'b1;
                        launch_base  = min_key;
                        state_d      = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // Only an empty range (min > max) can reach LAUNCH with base beyond max.
                    if (base_q > max_q) begin
                        not_found_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        core_start = active_c;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    for (int i = 0; i < N_CORES; i++) begin
                        if (core_finish[i] && active_c[i]) begin
                            done_mask_d[i]  = 1'b1;
                            valid_mask_d[i] = core_valid[i];
                        end
                    end
                    if ((done_mask_d & active_c) == active_c) begin
                        state_d = S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (win_any) begin
                        found_d      = 1'b1;
                        found_key_d  = base_q + KEY_W'(win_idx);
                        found_core_d = win_idx;
                        state_d      = S_DONE;
                    end else if (({1'b0, base_q} + EXT_W'(N_CORES)) > {1'b0, max_q}) begin
                        not_found_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        base_d       = base_q + KEY_W'(N_CORES);
                        done_mask_d  = '0;
                        valid_mask_d = '0;
                        load_launch  = 1'b1;
                        launch_base  = base_d;
                        state_d      = S_LAUNCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Keys are registered on entry to LAUNCH so they are already stable with the start pulse.
        if (load_launch) begin
            for (int i = 0; i < N_CORES; i++) begin
                core_key_d[i*KEY_W +: KEY_W] = launch_base + KEY_W'(i);
            end
            display_d = launch_base;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            max_q        <= '0;
            done_mask_q  <= '0;
            valid_mask_q <= '0;
            found_q      <= 1'b0;
            not_found_q  <= 1'b0;
            found_key_q  <= '0;
            found_core_q <= '0;
            core_key_q   <= '0;
            display_q    <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            max_q        <= max_d;
            done_mask_q  <= done_mask_d;
            valid_mask_q <= valid_mask_d;
            found_q      <= found_d;
            not_found_q  <= not_found_d;
            found_key_q  <= found_key_d;
            found_core_q <= found_core_d;
            core_key_q   <= core_key_d;
            display_q    <= display_d;
        end
    end

    assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_EVAL);
    assign found       = found_q;
    assign not_found   = not_found_q;
    assign found_key   = found_key_q;
    assign found_core  = found_core_q;
    assign core_key    = core_key_q;
    assign display_key = display_q;

`ifdef KEY_SEARCH_CYCLE_COUNT_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (start_accept) begin
            cycles_q <= '0;
        end else if (busy && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign search_cycles = cycles_q;
`else
    assign search_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: emulated cracking cores, table vectors, corner sequences and random ranges.
module tb_key_search_ctrl;

    localparam int KEY_W   = 24;
    localparam int N       = 4;
    localparam int IDX_W   = 4;
    localparam int SEEN_SZ = 4096;
    localparam int KEY_MAX = (1 << KEY_W) - 1;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  halt;
    logic [KEY_W-1:0]      min_key;
    logic [KEY_W-1:0]      max_key;
    logic [N-1:0]          core_start;
    logic [N*KEY_W-1:0]    core_key;
    logic [N-1:0]          core_finish;
    logic [N-1:0]          core_valid;
    logic                  busy;
    logic                  found;
    logic                  not_found;
    logic [KEY_W-1:0]      found_key;
    logic [IDX_W-1:0]      found_core;
    logic [KEY_W-1:0]      display_key;
    logic [31:0]           search_cycles;

    logic [N-1:0]          mdl_finish = '0;
    logic [N-1:0]          mdl_valid  = '0;
    logic [N-1:0]          spur_finish;
    logic [N-1:0]          spur_valid;
    assign core_finish = mdl_finish | spur_finish;
    assign core_valid  = mdl_valid | spur_valid;

    key_search_ctrl #(.KEY_W(KEY_W), .N_CORES(N), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .start(start), .halt(halt),
        .min_key(min_key), .max_key(max_key),
        .core_start(core_start), .core_key(core_key),
        .core_finish(core_finish), .core_valid(core_valid),
        .busy(busy), .found(found), .not_found(not_found),
        .found_key(found_key), .found_core(found_core),
        .display_key(display_key), .search_cycles(search_cycles)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- emulated cores ----------------
    int               lat_cfg[N];
    int               valid_a = -1;
    int               valid_b = -1;
    logic             cores_flush = 1'b0;
    int               cnt[N];
    logic [KEY_W-1:0] lkey[N];
    logic [KEY_W-1:0] seen_keys[SEEN_SZ];
    int               seen_n   = 0;
    int               stab_bad = 0;

    function automatic bit key_is_valid(input logic [KEY_W-1:0] k);
        return ((valid_a >= 0) && (int'(k) == valid_a)) || ((valid_b >= 0) && (int'(k) == valid_b));
    endfunction

    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            mdl_finish[i] = 1'b0;
            mdl_valid[i]  = 1'b0;
            if (reset === 1'b1 || cores_flush) begin
                cnt[i] = 0;
            end else begin
                if (cnt[i] > 0) begin
                    cnt[i] = cnt[i] - 1;
                    if (core_key[i*KEY_W +: KEY_W] !== lkey[i]) stab_bad = stab_bad + 1;
                    if (cnt[i] == 0) begin
                        mdl_finish[i] = 1'b1;
                        mdl_valid[i]  = key_is_valid(lkey[i]);
                    end
                end
                if (core_start[i] === 1'b1) begin
                    lkey[i] = core_key[i*KEY_W +: KEY_W];
                    cnt[i]  = lat_cfg[i];
                    seen_keys[seen_n % SEEN_SZ] = lkey[i];
                    seen_n = seen_n + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int               n_cmp = 0;
    int               n_err = 0;
    logic [KEY_W-1:0] exp_q[$];
    logic [N-1:0]     launch_pat[$];
    logic [KEY_W-1:0] launch_disp[$];
    int               busy_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the lowest valid key in range wins, sweeping whole batches of N upward from min.
    function automatic void ref_model(input int mn, input int mx, input int va, input int vb,
                                      output int e_found, output int e_nf, output int e_key,
                                      output int e_core, output int e_last, output int e_cycles);
        int best;
        int nb;
        best = -1;
        e_found = 0; e_nf = 0; e_key = 0; e_core = 0; e_last = mn - 1; e_cycles = 0;
        if (mn > mx) begin
            e_nf = 1;
            e_cycles = 1;
            return;
        end
        if (va >= mn && va <= mx) best = va;
        if (vb >= mn && vb <= mx && (best < 0 || vb < best)) best = vb;
        if (best >= 0) begin
            e_found = 1;
            e_key   = best;
            e_core  = (best - mn) % N;
            e_last  = mn + ((best - mn) / N + 1) * N - 1;
            if (e_last > mx) e_last = mx;
        end else begin
            e_nf   = 1;
            e_last = mx;
        end
        nb = (e_last - mn) / N + 1;
        for (int b = 0; b < nb; b++) begin
            int n_act;
            int ml;
            n_act = e_last - (mn + b * N) + 1;
            if (n_act > N) n_act = N;
            ml = 0;
            for (int c = 0; c < n_act; c++) if (lat_cfg[c] > ml) ml = lat_cfg[c];
            e_cycles += ml + 2;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pulse(input int mn, input int mx);
        min_key = KEY_W'(mn);
        max_key = KEY_W'(mx);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        busy_cnt = 0;
        launch_pat.delete();
        launch_disp.delete();
        while (busy === 1'b1 && busy_cnt < budget) begin
            if (core_start !== '0) begin
                launch_pat.push_back(core_start);
                launch_disp.push_back(display_key);
            end
            busy_cnt++;
            tick();
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: busy=%b after %0d cycles, expected 0", busy, budget);
        end
    endtask

    task automatic run_check(input string name, input int mn, input int mx, input int va, input int vb,
                             input int ef, input int enf, input int ek, input int ec, input int es);
        int mf, mnf, mk, mc, last, cyc, base_seen, nb;
        ref_model(mn, mx, va, vb, mf, mnf, mk, mc, last, cyc);
        valid_a   = va;
        valid_b   = vb;
        base_seen = seen_n;
        start_pulse(mn, mx);
        wait_done(4000);
        check({name, ".found"}, 32'(found), ef);
        check({name, ".not_found"}, 32'(not_found), enf);
        check({name, ".found_key"}, 32'(found_key), ek);
        check({name, ".found_core"}, 32'(found_core), ec);
        check({name, ".starts"}, seen_n - base_seen, es);
        check({name, ".busy_cycles"}, busy_cnt, cyc);
`ifdef KEY_SEARCH_CYCLE_COUNT_EN
        check({name, ".search_cycles"}, search_cycles, cyc);
`else
        check({name, ".search_cycles"}, search_cycles, 0);
`endif
        exp_q.delete();
        for (int k = mn; k <= last; k++) exp_q.push_back(KEY_W'(k));
        for (int s = base_seen; s < seen_n && exp_q.size() > 0; s++)
            check({name, ".launch_key"}, 32'(seen_keys[s % SEEN_SZ]), 32'(exp_q.pop_front()));
        nb = (mn <= mx) ? (last - mn) / N + 1 : 0;
        check({name, ".batches"}, launch_pat.size(), nb);
        for (int b = 0; b < nb && b < launch_pat.size(); b++) begin
            int n_act;
            n_act = last - (mn + b * N) + 1;
            if (n_act > N) n_act = N;
            check({name, ".core_start"}, 32'(launch_pat[b]), (1 << n_act) - 1);
            check({name, ".display_key"}, 32'(launch_disp[b]), mn + b * N);
        end
    endtask

    task automatic set_lat(input int l);
        for (int i = 0; i < N; i++) lat_cfg[i] = l;
    endtask

    task automatic flush_cores();
        cores_flush = 1'b1;
        tick();
        cores_flush = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int mn; int mx; int va; int vb; int lat;
        int e_found; int e_nf; int e_key; int e_core; int e_starts;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int mn, mx, va, vb, mf, mnf, mk, mc, last, cyc, sb;

        vecs[0] = '{0, 9, 6, -1, 5, 1, 0, 6, 2, 8};
        vecs[1] = '{0, 9, -1, -1, 3, 0, 1, 0, 0, 10};
        vecs[2] = '{0, 9, 5, 7, 4, 1, 0, 5, 1, 8};
        vecs[3] = '{5, 3, 4, -1, 2, 0, 1, 0, 0, 0};
        vecs[4] = '{KEY_MAX - 1, KEY_MAX, -1, -1, 3, 0, 1, 0, 0, 2};
        vecs[5] = '{KEY_MAX - 1, KEY_MAX, KEY_MAX, -1, 2, 1, 0, KEY_MAX, 1, 2};
        vecs[6] = '{100, 200, 150, 160, 1, 1, 0, 150, 2, 52};
        vecs[7] = '{7, 7, 7, -1, 6, 1, 0, 7, 0, 1};

        reset = 1'b1; start = 1'b0; halt = 1'b0;
        min_key = '0; max_key = '0;
        spur_finish = '0; spur_valid = '0;
        set_lat(1);
        tick(); tick();
        reset = 1'b0;

        check("rst.busy", 32'(busy), 0);
        check("rst.found", 32'(found), 0);
        check("rst.not_found", 32'(not_found), 0);
        check("rst.found_key", 32'(found_key), 0);
        check("rst.found_core", 32'(found_core), 0);
        check("rst.display_key", 32'(display_key), 0);
        check("rst.core_key", 32'(|core_key), 0);
        check("rst.core_start", 32'(core_start), 0);
        check("rst.search_cycles", search_cycles, 0);

        for (int v = 0; v < 8; v++) begin
            set_lat(vecs[v].lat);
            run_check($sformatf("vec%0d", v), vecs[v].mn, vecs[v].mx, vecs[v].va, vecs[v].vb,
                      vecs[v].e_found, vecs[v].e_nf, vecs[v].e_key, vecs[v].e_core, vecs[v].e_starts);
        end

        // halt while DONE keeps the latched result
        halt = 1'b1; tick(); halt = 1'b0;
        check("halt_done.found", 32'(found), 1);
        check("halt_done.found_key", 32'(found_key), 7);
        check("halt_done.not_found", 32'(not_found), 0);

        // empty range: not_found two edges after start, nothing launched
        sb = seen_n;
        start_pulse(5, 3);
        check("empty.busy", 32'(busy), 1);
        check("empty.not_found_early", 32'(not_found), 0);
        tick();
        check("empty.not_found", 32'(not_found), 1);
        check("empty.busy_after", 32'(busy), 0);
        check("empty.starts", seen_n - sb, 0);

        // top-of-range batch, halted mid-WAIT, then clean restart
        set_lat(8);
        valid_a = KEY_MAX; valid_b = -1;
        start_pulse(KEY_MAX - 1, KEY_MAX);
        check("top.core_start", 32'(core_start), 32'h3);
        tick(); tick();
        halt = 1'b1; tick(); halt = 1'b0;
        check("halt_wait.busy", 32'(busy), 0);
        check("halt_wait.found", 32'(found), 0);
        check("halt_wait.not_found", 32'(not_found), 0);
        flush_cores();
        run_check("restart", KEY_MAX - 1, KEY_MAX, KEY_MAX, -1, 1, 0, KEY_MAX, 1, 2);

        // halt during LAUNCH suppresses the start pulses
        sb = seen_n;
        start_pulse(0, 9);
        halt = 1'b1;
        #1;
        check("halt_launch.core_start", 32'(core_start), 0);
        tick();
        halt = 1'b0;
        check("halt_launch.busy", 32'(busy), 0);
        check("halt_launch.starts", seen_n - sb, 0);

        // start while busy is ignored
        set_lat(5);
        valid_a = 6; valid_b = -1;
        sb = seen_n;
        start_pulse(0, 9);
        tick(); tick();
        start_pulse(50, 60);
        wait_done(4000);
        check("busy_start.found_key", 32'(found_key), 6);
        check("busy_start.found", 32'(found), 1);
        check("busy_start.starts", seen_n - sb, 8);

        // finishes from inactive cores are ignored
        set_lat(6);
        valid_a = -1;
        start_pulse(8, 9);
        check("spur.core_start", 32'(core_start), 32'h3);
        tick();
        spur_finish = 4'b1100; spur_valid = 4'b1100;
        tick();
        spur_finish = '0; spur_valid = '0;
        wait_done(4000);
        check("spur.found", 32'(found), 0);
        check("spur.not_found", 32'(not_found), 1);
        check("spur.busy_cycles", busy_cnt + 2, 8);

        // reset mid-search
        set_lat(5);
        start_pulse(0, 9);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_mid.busy", 32'(busy), 0);
        check("rst_mid.core_key", 32'(|core_key), 0);
        check("rst_mid.display_key", 32'(display_key), 0);
        check("rst_mid.core_start", 32'(core_start), 0);
        check("rst_mid.search_cycles", search_cycles, 0);

        // randomized ranges against the reference model
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                mx = KEY_MAX - int'($urandom_range(0, 2));
                mn = mx - int'($urandom_range(0, 14)) + 2;
                if (mn > KEY_MAX) mn = KEY_MAX;
            end else begin
                mn = int'($urandom_range(0, 1000));
                mx = mn + int'($urandom_range(0, 30)) - 2;
                if (mx < 0) mx = 0;
            end
            va = ($urandom_range(0, 1) == 1) ? mn + int'($urandom_range(0, 31)) : -1;
            vb = ($urandom_range(0, 2) == 0) ? mn + int'($urandom_range(0, 31)) : -1;
            for (int i = 0; i < N; i++) lat_cfg[i] = int'($urandom_range(1, 6));
            ref_model(mn, mx, va, vb, mf, mnf, mk, mc, last, cyc);
            run_check($sformatf("rnd%0d", t), mn, mx, va, vb, mf, mnf, mk, mc,
                      (mn <= mx) ? last - mn + 1 : 0);
        end

        check("key_stability", stab_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_search_ctrl.md
Name: key_search_ctrl

Overview:
- Parametrised multi-core key-search sequencer for the RC4 cracking datapath.
- Sweeps a run-time key range [min_key, max_key] across N_CORES decrypt/check cores in lockstep batches.
- Launches each active core with its own key, collects finish/valid pulses, and stops on the first valid key (lowest key wins) or on range exhaustion.
- Sits above the per-core setup/scramble/decode/check pipelines; drives the found/not_found LEDs and the key display.

Parameters:
- KEY_W, 24, key width in bits.
- N_CORES, 4, number of parallel cracking cores (1..16).
- IDX_W, 4, width of the winning-core index (must satisfy 2^IDX_W >= N_CORES).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pulse: begin a search; honoured only in IDLE or DONE
- halt  in  1  level: abort to DONE from any state
- min_key  in  KEY_W  first key to try; sampled on accepted start
- max_key  in  KEY_W  last key to try (inclusive); sampled on accepted start
- core_start  out  N_CORES  one-cycle start pulse per core
- core_key  out  N_CORES*KEY_W  key for core i in bits [i*KEY_W +: KEY_W]; held stable from launch to evaluation
- core_finish  in  N_CORES  one-cycle done pulse per core
- core_valid  in  N_CORES  core result is plaintext-valid; sampled in the same cycle as core_finish
- busy  out  1  search in progress
- found  out  1  sticky: a valid key was found
- not_found  out  1  sticky: range exhausted without a valid key
- found_key  out  KEY_W  winning key; 0 unless found
- found_core  out  IDX_W  index of the winning core
- display_key  out  KEY_W  base key of the current batch (key given to core 0)
- search_cycles  out  32  cycle count of the last or current search (see Optional Feature)

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: core_start, core_key, busy, found, not_found, found_key, found_core, display_key, search_cycles.
- States: IDLE, LAUNCH, WAIT, EVAL, DONE.
- Accepting start (IDLE or DONE):
  - Latch min_key and max_key.
  - base <= min_key; clear found, not_found, found_key, found_core, done_mask and valid_mask.
  - Go to LAUNCH; busy = 1 from the next cycle.
  - If min_key > max_key, go straight to DONE with not_found = 1 one cycle later; no core is launched.
  - start is ignored while busy.
- LAUNCH (1 cycle):
  - Key for core i is base + i, computed in KEY_W+1 bits.
  - active[i] = (base + i <= max_key), with no wrap past 2^KEY_W - 1.
  - core_start[i] = active[i] for exactly this cycle.
  - core_key is registered, and display_key = base.
  - Next state WAIT.
- WAIT:
  - On core_finish[i], set done_mask[i] and set valid_mask[i] = core_valid[i].
  - Finish pulses from inactive cores are ignored.
  - When (done_mask & active) == active, go to EVAL. Simultaneous finishes in one cycle are all captured.
- EVAL (1 cycle):
  - If any valid_mask bit is set:
    - Pick the lowest-index valid core j.
    - found_key = base + j, found_core = j, found = 1.
    - Next state DONE.
  - Else, if base + N_CORES > max_key (KEY_W+1-bit compare): not_found = 1, next state DONE.
  - Else: base += N_CORES, clear the masks, next state LAUNCH.
- DONE:
  - busy = 0; found and not_found hold until the next accepted start or reset.
  - found and not_found are never both 1.
- halt:
  - Any state goes to DONE on the next edge.
  - halt in LAUNCH still suppresses the core_start pulse.
  - found and not_found are not set by halt; a previously latched found_key is kept.
  - halt has priority over start.
- Reset mid-search returns everything to the reset values on the next edge.
- Max-key edge: max_key = 2^KEY_W - 1 terminates correctly, with no wrap back to 0.

Optional Feature:
- Macro: KEY_SEARCH_CYCLE_COUNT_EN.
- Defined:
  - search_cycles clears to 0 on an accepted start.
  - It increments by 1 every cycle while busy, saturating at 32'hFFFF_FFFF.
  - It holds in DONE.
- Undefined: search_cycles is tied to 0 and no counter logic is built.

Test Plan:
- N_CORES=4, min=0, max=9; core valid only for key 6 (finish 5 cycles after its start) -> 2 batches. Second batch (base 4) gives found=1, found_key=6, found_core=2, not_found=0, busy=0.
- min=0, max=9, no key valid -> batches at base 0, 4, 8. Third batch: core_start=4'b0011. Then not_found=1, found=0; the extra launch count per batch is exactly the active count.
- Same batch, cores 1 and 3 both valid, finishing in the same cycle -> found_key=base+1, found_core=1.
- min=5, max=3 -> no core_start is ever asserted; not_found=1 two cycles after start.
- max=24'hFFFFFF, min=24'hFFFFFE -> core_start=4'b0011 and no wrap. Halt asserted mid-WAIT -> DONE next edge, found=0, not_found=0. A start then restarts cleanly.
- With KEY_SEARCH_CYCLE_COUNT_EN and cores finishing 3 cycles after start: search_cycles equals the busy-high cycle count. Without the macro it stays 0.
